mod_counter_ctrl: RTL and testbench

Controller that sequences a programmable modulus-N counter through a configured number of complete wraps under a start/done handshake. It supports pause, abort and config-error reporting. It sits above the team's fixed-modulus counters (e.g. the modulus-6 counter): it generalises N to a run-time value and adds the control plane that a host FSM or testbench uses to launch and monitor counting runs.

---
 rtl/mod_counter_pkg.sv | 14 +
 rtl/mod_n_counter.sv | 44 ++++
 rtl/mod_counter_ctrl.sv | 122 ++++++++++++
 tb/tb_mod_counter_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulus-N counter controller.
//   state_e : controller FSM states
//   MIN_MOD : smallest modulus the controller accepts
package mod_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MIN_MOD = 2;

endpackage

// File: rtl/mod_n_counter.sv
// Generic modulus-N up-counter: counts 0..n-1 and wraps to 0.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   en  : advance the count this cycle
//   clr : synchronous clear to 0 (wins over en)
//   n   : modulus
//   q   : current count
//   tc  : high when enabled and q == n-1 (the cycle that wraps)
module mod_n_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] q_q, q_d;

  assign tc = en & (q_q == (n - WIDTH'(1)));
  assign q  = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = tc ? '0 : q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Run controller for a programmable modulus-N counter: on an accepted start it
// counts W complete wraps of 0..N-1, then pulses done. Supports pause, abort
// and a sticky config-error flag for rejected starts.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   cfg_mod, cfg_wraps: modulus N and wrap count W, sampled on accepted start
//   start, pause, abort: control inputs
//   q, tc             : counter value and terminal-count flag (tc is combinational)
//   wrap_cnt          : wraps completed in current/last run
//   busy, done, err   : running, one-cycle completion, sticky config error
module mod_counter_ctrl
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cfg_mod,
  input  logic [CNT_W-1:0] cfg_wraps,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] MinMod = WIDTH'(MIN_MOD);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic [CNT_W-1:0] wrap_q, wrap_d;
  logic [CNT_W-1:0] wrap_inc;
  logic             err_q, err_d;
  logic             cfg_ok, accept, cnt_en, cnt_clr, cnt_tc;

  assign cfg_ok   = (cfg_mod >= MinMod) && (cfg_wraps != '0);
  assign accept   = (state_q == IDLE) && start && cfg_ok;
  // Abort outranks pause, which outranks counting.
  assign cnt_en   = (state_q == RUN) && !pause && !abort;
  assign cnt_clr  = accept || ((state_q == RUN) && abort);
  assign wrap_inc = wrap_q + CNT_W'(1);

  mod_n_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk(clk),
    .rst(rst),
    .en (cnt_en),
    .clr(cnt_clr),
    .n  (n_q),
    .q  (q),
    .tc (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    w_d     = w_q;
    wrap_d  = wrap_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            n_d     = cfg_mod;
            w_d     = cfg_wraps;
            wrap_d  = '0;
            err_d   = 1'b0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          wrap_d = wrap_inc;
          if (wrap_inc == w_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      w_q     <= '0;
      wrap_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      w_q     <= w_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign tc       = cnt_tc;
  assign wrap_cnt = wrap_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed self-checking bench for mod_counter_ctrl.
module tb_mod_counter_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] cfg_mod;
  logic [7:0] cfg_wraps;
  logic       start, pause, abort;
  logic [3:0] q;
  logic       tc;
  logic [7:0] wrap_cnt;
  logic       busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  mod_counter_ctrl #(
    .WIDTH(4),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mod  (cfg_mod),
    .cfg_wraps(cfg_wraps),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .q        (q),
    .tc       (tc),
    .wrap_cnt (wrap_cnt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int eq, input int etc, input int ewrap,
                            input int ebusy, input int edone, input int eerr);
    check({tag, ".q"},    32'(q),        32'(eq));
    check({tag, ".tc"},   32'(tc),       32'(etc));
    check({tag, ".wrap"}, 32'(wrap_cnt), 32'(ewrap));
    check({tag, ".busy"}, 32'(busy),     32'(ebusy));
    check({tag, ".done"}, 32'(done),     32'(edone));
    check({tag, ".err"},  32'(err),      32'(eerr));
  endtask

  initial begin
    rst = 1'b1; cfg_mod = 4'd0; cfg_wraps = 8'd0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    #2 rst = 1'b0;
    #1 check_outs("reset", 0, 0, 0, 0, 0, 0);
    #5 rst = 1'b1;
    tick();

    // Run N=6, W=2: 12 counting cycles, done after the 12th edge.
    cfg_mod = 4'd6; cfg_wraps = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check_outs("run6", c % 6, (c % 6 == 5) ? 1 : 0, (c < 6) ? 0 : 1, 1, 0, 0);
      tick();
    end
    check_outs("run6_done", 0, 0, 2, 0, 1, 0);
    tick();
    check_outs("run6_idle", 0, 0, 2, 0, 0, 0);

    // Illegal modulus raises err and stays idle.
    cfg_mod = 4'd1; cfg_wraps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("bad_cfg", 0, 0, 2, 0, 0, 1);
    tick();
    check_outs("bad_cfg_hold", 0, 0, 2, 0, 0, 1);
    // Valid start clears err; N=3, W=1 finishes 3 edges later.
    cfg_mod = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("run3_k", 0, 0, 0, 1, 0, 0);
    tick(); tick();
    check_outs("run3_last", 2, 1, 0, 1, 0, 0);
    tick();
    check_outs("run3_done", 0, 0, 1, 0, 1, 0);
    tick();

    // N=5, W=3 with 4 paused cycles at q=2: done after edge k+19.
    cfg_mod = 4'd5; cfg_wraps = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    pause = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check_outs("pause", 2, 0, 0, 1, 0, 0);
      tick();
    end
    pause = 1'b0;
    check_outs("unpause", 2, 0, 0, 1, 0, 0);
    for (int c = 0; c < 12; c++) tick();
    check_outs("run5_last", 4, 1, 2, 1, 0, 0);
    tick();
    check_outs("run5_done", 0, 0, 3, 0, 1, 0);
    tick();

    // N=4, W=2: abort in the final-wrap cycle suppresses done and the wrap.
    cfg_mod = 4'd4; cfg_wraps = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check_outs("pre_abort", 3, 1, 1, 1, 0, 0);
    abort = 1'b1;
    #1 check("abort_tc", 32'(tc), 32'd0);
    tick();
    abort = 1'b0;
    check_outs("aborted", 0, 0, 1, 0, 0, 0);
    tick();
    check_outs("aborted2", 0, 0, 1, 0, 0, 0);

    // Start held high, N=2, W=1: done every 4 cycles; start in RUN/DONE ignored.
    cfg_mod = 4'd2; cfg_wraps = 8'd1; start = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      check({"b2b.done"}, 32'(done), (c % 4 == 2) ? 32'd1 : 32'd0);
      check({"b2b.busy"}, 32'(busy), (c % 4 < 2) ? 32'd1 : 32'd0);
      check({"b2b.q"},    32'(q),    (c % 4 == 1) ? 32'd1 : 32'd0);
      if (c == 7) start = 1'b0;
      tick();
    end
    check_outs("b2b_end", 0, 0, 1, 0, 0, 0);

    // Asynchronous reset mid-run at q=3.
    cfg_mod = 4'd6; cfg_wraps = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check_outs("pre_rst", 3, 0, 0, 1, 0, 0);
    #2 rst = 1'b0;
    #1 check_outs("async_rst", 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_outs("post_rst", 0, 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
